// File: rtl/kvt_clk_gen_pkg.sv
// Shared types for the multi-channel clock generator: command opcodes and
// per-channel FSM states.
package kvt_clk_gen_pkg;

  typedef enum logic [1:0] {
    START      = 2'd0,
    STOP       = 2'd1,
    SET_PERIOD = 2'd2,
    RSVD       = 2'd3
  } cfg_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_HI   = 2'd1,
    RUN_LO   = 2'd2,
    STOPPING = 2'd3
  } ch_state_e;

endpackage

// File: rtl/kvt_clk_gen_ch.sv
// One divided-clock channel: half-period counter, active/shadow half registers
// and a glitch-free stop that never truncates a high phase.
module kvt_clk_gen_ch
  import kvt_clk_gen_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  cfg_op_e          cmd_op,
  input  logic [DIV_W-1:0] cmd_half,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             running,
  output logic             stopping
);

  ch_state_e        state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] act_reg, act_next;
  logic [DIV_W-1:0] shd_reg, shd_next;
  logic             clk_reg, clk_next;
  logic             rise_reg, rise_next;
  logic             run_reg;
  logic             is_start, is_stop, is_set;

  assign is_start = cmd_valid && (cmd_op == START);
  assign is_stop  = cmd_valid && (cmd_op == STOP);
  assign is_set   = cmd_valid && (cmd_op == SET_PERIOD);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    act_next   = act_reg;
    shd_next   = shd_reg;
    clk_next   = clk_reg;
    rise_next  = 1'b0;
    if (state_reg == IDLE) begin
      if (is_start) begin
        state_next = RUN_HI;
        clk_next   = 1'b1;
        rise_next  = 1'b1;
        act_next   = cmd_half;
        shd_next   = cmd_half;
        cnt_next   = cmd_half - DIV_W'(1);
      end else if (is_set) begin
        act_next = cmd_half;
        shd_next = cmd_half;
      end
    end else begin
      // A new half-period only lands in the shadow; the running phase keeps its length.
      if ((is_start || is_set) && state_reg != STOPPING) shd_next = cmd_half;
      if (cnt_reg == '0) begin
        act_next = shd_reg;
        cnt_next = shd_reg - DIV_W'(1);
        clk_next = ~clk_reg;
        case (state_reg)
          RUN_HI:   state_next = is_stop ? IDLE : RUN_LO;
          RUN_LO: begin
            state_next = RUN_HI;
            rise_next  = 1'b1;
          end
          default: begin
            state_next = IDLE;
            clk_next   = 1'b0;
            cnt_next   = '0;
          end
        endcase
      end else begin
        cnt_next = cnt_reg - DIV_W'(1);
        if (state_reg == RUN_HI && is_stop) state_next = STOPPING;
      end
      if (state_reg == RUN_LO && is_stop) begin
        state_next = IDLE;
        clk_next   = 1'b0;
        rise_next  = 1'b0;
        cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      act_reg   <= '0;
      shd_reg   <= '0;
      clk_reg   <= 1'b0;
      rise_reg  <= 1'b0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      act_reg   <= act_next;
      shd_reg   <= shd_next;
      clk_reg   <= clk_next;
      rise_reg  <= rise_next;
      run_reg   <= (state_next != IDLE);
    end
  end

  assign clk_out    = clk_reg;
  assign rise_pulse = rise_reg;
  assign running    = run_reg;
  assign stopping   = (state_reg == STOPPING);

endmodule

// File: rtl/kvt_clk_gen_multi.sv
// Multi-channel clock generator: decodes the shared command port, flags illegal
// commands and fans legal ones out to NUM_CH independent channels.
module kvt_clk_gen_multi
  import kvt_clk_gen_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DIV_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_op,
  input  logic [DIV_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] running,
  output logic              err
);

  cfg_op_e           op;
  logic [NUM_CH-1:0] stopping;
  logic              ch_ok, half_bad, illegal, accept;
  logic              err_reg;

  assign op       = cfg_op_e'(cfg_op);
  assign ch_ok    = (int'(cfg_ch) < NUM_CH);
  assign half_bad = (op == START || op == SET_PERIOD) && (cfg_half == '0);
  assign illegal  = (op == RSVD) || half_bad || !ch_ok;
  assign accept   = cfg_valid && cfg_ready;

  // Back-pressure only while the addressed channel finishes its high phase.
  always_comb begin
    cfg_ready = !rst;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i) && stopping[i]) cfg_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_reg <= 1'b0;
    else     err_reg <= accept && illegal;
  end

  assign err = err_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      kvt_clk_gen_ch #(
        .DIV_W(DIV_W)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (accept && !illegal && (cfg_ch == CH_W'(gi))),
        .cmd_op     (op),
        .cmd_half   (cfg_half),
        .clk_out    (clk_out[gi]),
        .rise_pulse (rise_pulse[gi]),
        .running    (running[gi]),
        .stopping   (stopping[gi])
      );
    end
  endgenerate

endmodule
